regfile_param: RTL and testbench

- Parametrised multi-read-port register file with a hardwired constant register 0, optional write-to-read bypass and optional registered (1-cycle) reads.
- Adds a per-register pending scoreboard: the issue stage marks a destination register busy, and the later write-back clears it. Read ports report whether their data is valid.
- Sits between the decode/issue stage (read and issue side) and write-back (write side) of the datapath.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_if.sv | 30 +++
 rtl/regfile_rdport.sv | 75 +++++++
 rtl/regfile_param.sv | 80 ++++++++
 tb/tb_regfile_param.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, helpers and read-result type for the register file slice.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned ADDR_W_DEF   = 3;
   localparam int unsigned DEPTH_DEF    = 8;
   localparam int unsigned R0_VALUE_DEF = 13;

   // Widest supported register; read results are carried at this width.
   localparam int unsigned DATA_W_MAX   = 64;

   typedef struct packed {
      logic [DATA_W_MAX-1:0] data;
      logic                  valid;
   } rd_result_t;

   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Issue/write-back/read bundle between the datapath stages and the register file.
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              issue;
   logic [ADDR_W-1:0] iaddr;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic              rvalid1;
   logic              rvalid2;
   logic              pend_any;

   modport master (
      output we, waddr, wdata, issue, iaddr, raddr1, raddr2,
      input  rdata1, rdata2, rvalid1, rvalid2, pend_any
   );

   modport slave (
      input  we, waddr, wdata, issue, iaddr, raddr1, raddr2,
      output rdata1, rdata2, rvalid1, rvalid2, pend_any
   );
endinterface

// File: rtl/regfile_rdport.sv
// One read port: address decode, fixed R0, out-of-range, write bypass and
// optional output register.
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned R0_FIXED = 1,
   parameter int unsigned R0_VALUE = R0_VALUE_DEF,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned READ_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] regs [DEPTH],
   input  logic [DEPTH-1:0]  pend,
   input  logic              wr_ok,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              issue_ok,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid
);

   logic [DATA_W-1:0] sel_data;
   logic              sel_pend;
   rd_result_t        res;
   rd_result_t        res_q;
   logic              unused_hi;

   // Storage/scoreboard select without indexing past DEPTH.
   always_comb begin
      sel_data = '0;
      sel_pend = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (raddr == ADDR_W'(i)) begin
            sel_data = regs[i];
            sel_pend = pend[i];
         end
      end
   end

   // A same-cycle issue to the bypassed address keeps the scoreboard verdict.
   always_comb begin
      res.data  = '0;
      res.valid = 1'b1;
      if (addr_in_range(32'(raddr), DEPTH)) begin
         if ((R0_FIXED != 0) && (raddr == '0)) begin
            res.data = DATA_W_MAX'(R0_VALUE);
         end else if ((BYPASS != 0) && wr_ok && (waddr == raddr)) begin
            res.data  = DATA_W_MAX'(wdata);
            res.valid = !(issue_ok && (iaddr == raddr)) || !sel_pend;
         end else begin
            res.data  = DATA_W_MAX'(sel_data);
            res.valid = !sel_pend;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= '{data: '0, valid: 1'b1};
      end else begin
         res_q <= res;
      end
   end

   assign rdata     = (READ_REG != 0) ? res_q.data[DATA_W-1:0] : res.data[DATA_W-1:0];
   assign rvalid    = (READ_REG != 0) ? res_q.valid : res.valid;
   assign unused_hi = ^{res.data[DATA_W_MAX-1:DATA_W], res_q.data[DATA_W_MAX-1:DATA_W]};

endmodule

// File: rtl/regfile_param.sv
// Two-read-port register file with constant R0, optional bypass/registered reads
// and a per-register pending scoreboard between issue and write-back.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned R0_FIXED = 1,
   parameter int unsigned R0_VALUE = R0_VALUE_DEF,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned READ_REG = 0
) (
   input logic      clk,
   input logic      rst,
   regfile_if.slave bus
);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic              wr_ok;
   logic              issue_ok;

   assign wr_ok    = bus.we && addr_in_range(32'(bus.waddr), DEPTH)
                     && !((R0_FIXED != 0) && (bus.waddr == '0));
   assign issue_ok = bus.issue && addr_in_range(32'(bus.iaddr), DEPTH)
                     && !((R0_FIXED != 0) && (bus.iaddr == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= (i == 0) ? DATA_W'(R0_VALUE) : '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_ok && (bus.waddr == ADDR_W'(i))) begin
               regs[i] <= bus.wdata;
            end
         end
      end
   end

   // Issue beats write-back on the same register: the new producer owns it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (issue_ok && (bus.iaddr == ADDR_W'(i))) begin
               pend[i] <= 1'b1;
            end else if (wr_ok && (bus.waddr == ADDR_W'(i))) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   assign bus.pend_any = |pend;

   regfile_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .R0_FIXED(R0_FIXED),
      .R0_VALUE(R0_VALUE), .BYPASS(BYPASS), .READ_REG(READ_REG)
   ) u_rd1 (
      .clk(clk), .rst(rst), .raddr(bus.raddr1), .regs(regs), .pend(pend),
      .wr_ok(wr_ok), .waddr(bus.waddr), .wdata(bus.wdata),
      .issue_ok(issue_ok), .iaddr(bus.iaddr),
      .rdata(bus.rdata1), .rvalid(bus.rvalid1)
   );

   regfile_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .R0_FIXED(R0_FIXED),
      .R0_VALUE(R0_VALUE), .BYPASS(BYPASS), .READ_REG(READ_REG)
   ) u_rd2 (
      .clk(clk), .rst(rst), .raddr(bus.raddr2), .regs(regs), .pend(pend),
      .wr_ok(wr_ok), .waddr(bus.waddr), .wdata(bus.wdata),
      .issue_ok(issue_ok), .iaddr(bus.iaddr),
      .rdata(bus.rdata2), .rvalid(bus.rvalid2)
   );

endmodule

// File: tb/tb_regfile_param.sv
// Four register-file configurations driven in lockstep and checked against a
// behavioural model of storage, scoreboard and read rules.
module tb_regfile_param;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_if ia ();
   regfile_if ib ();
   regfile_if ic ();
   regfile_if id ();

   // A: defaults; B: no bypass; C: registered reads; D: DEPTH=6, writable R0.
   regfile_param #(.BYPASS(1), .READ_REG(0)) u_a (.clk(clk), .rst(rst), .bus(ia));
   regfile_param #(.BYPASS(0), .READ_REG(0)) u_b (.clk(clk), .rst(rst), .bus(ib));
   regfile_param #(.BYPASS(1), .READ_REG(1)) u_c (.clk(clk), .rst(rst), .bus(ic));
   regfile_param #(.DEPTH(6), .R0_FIXED(0))  u_d (.clk(clk), .rst(rst), .bus(id));

   int n_cmp = 0;
   int n_bad = 0;

   bit t_we, t_issue;
   int t_waddr, t_wdata, t_iaddr, t_r1, t_r2;

   // Model state: index 0 = DEPTH 8 with fixed R0, index 1 = DEPTH 6 writable R0.
   int m_regs [2][8];
   bit m_pend [2][8];
   int q_d [2];
   bit q_v [2];

   function automatic int depth_of(input int c);
      return (c == 0) ? 8 : 6;
   endfunction

   function automatic bit r0_fixed(input int c);
      return c == 0;
   endfunction

   function automatic bit wr_ok(input int c);
      return t_we && (t_waddr < depth_of(c)) && !(r0_fixed(c) && t_waddr == 0);
   endfunction

   function automatic bit iss_ok(input int c);
      return t_issue && (t_iaddr < depth_of(c)) && !(r0_fixed(c) && t_iaddr == 0);
   endfunction

   function automatic void exp_read(input int c, input int addr, input bit byp,
                                    output int d, output bit v);
      if (addr >= depth_of(c)) begin
         d = 0; v = 1'b1;
      end else if (r0_fixed(c) && addr == 0) begin
         d = 13; v = 1'b1;
      end else if (byp && wr_ok(c) && t_waddr == addr) begin
         d = t_wdata;
         v = (iss_ok(c) && t_iaddr == addr) ? !m_pend[c][addr] : 1'b1;
      end else begin
         d = m_regs[c][addr]; v = !m_pend[c][addr];
      end
   endfunction

   function automatic bit exp_pend_any(input int c);
      bit any = 1'b0;
      for (int i = 0; i < 8; i++) any |= m_pend[c][i];
      return any;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic drive();
      ia.we = t_we; ia.waddr = 3'(t_waddr); ia.wdata = 8'(t_wdata);
      ia.issue = t_issue; ia.iaddr = 3'(t_iaddr); ia.raddr1 = 3'(t_r1); ia.raddr2 = 3'(t_r2);
      ib.we = t_we; ib.waddr = 3'(t_waddr); ib.wdata = 8'(t_wdata);
      ib.issue = t_issue; ib.iaddr = 3'(t_iaddr); ib.raddr1 = 3'(t_r1); ib.raddr2 = 3'(t_r2);
      ic.we = t_we; ic.waddr = 3'(t_waddr); ic.wdata = 8'(t_wdata);
      ic.issue = t_issue; ic.iaddr = 3'(t_iaddr); ic.raddr1 = 3'(t_r1); ic.raddr2 = 3'(t_r2);
      id.we = t_we; id.waddr = 3'(t_waddr); id.wdata = 8'(t_wdata);
      id.issue = t_issue; id.iaddr = 3'(t_iaddr); id.raddr1 = 3'(t_r1); id.raddr2 = 3'(t_r2);
   endtask

   task automatic check_all();
      int d; bit v;
      exp_read(0, t_r1, 1'b1, d, v); chk("A.rdata1", 32'(ia.rdata1), 32'(d)); chk("A.rvalid1", 32'(ia.rvalid1), 32'(v));
      exp_read(0, t_r2, 1'b1, d, v); chk("A.rdata2", 32'(ia.rdata2), 32'(d)); chk("A.rvalid2", 32'(ia.rvalid2), 32'(v));
      exp_read(0, t_r1, 1'b0, d, v); chk("B.rdata1", 32'(ib.rdata1), 32'(d)); chk("B.rvalid1", 32'(ib.rvalid1), 32'(v));
      exp_read(0, t_r2, 1'b0, d, v); chk("B.rdata2", 32'(ib.rdata2), 32'(d)); chk("B.rvalid2", 32'(ib.rvalid2), 32'(v));
      chk("C.rdata1", 32'(ic.rdata1), 32'(q_d[0])); chk("C.rvalid1", 32'(ic.rvalid1), 32'(q_v[0]));
      chk("C.rdata2", 32'(ic.rdata2), 32'(q_d[1])); chk("C.rvalid2", 32'(ic.rvalid2), 32'(q_v[1]));
      exp_read(1, t_r1, 1'b1, d, v); chk("D.rdata1", 32'(id.rdata1), 32'(d)); chk("D.rvalid1", 32'(id.rvalid1), 32'(v));
      exp_read(1, t_r2, 1'b1, d, v); chk("D.rdata2", 32'(id.rdata2), 32'(d)); chk("D.rvalid2", 32'(id.rvalid2), 32'(v));
      chk("A.pend_any", 32'(ia.pend_any), 32'(exp_pend_any(0)));
      chk("B.pend_any", 32'(ib.pend_any), 32'(exp_pend_any(0)));
      chk("C.pend_any", 32'(ic.pend_any), 32'(exp_pend_any(0)));
      chk("D.pend_any", 32'(id.pend_any), 32'(exp_pend_any(1)));
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 8; i++) begin
            m_regs[c][i] = (i == 0) ? 13 : 0;
            m_pend[c][i] = 1'b0;
         end
      end
      q_d[0] = 0; q_d[1] = 0; q_v[0] = 1'b1; q_v[1] = 1'b1;
   endtask

   task automatic model_clock();
      int d; bit v;
      exp_read(0, t_r1, 1'b1, d, v); q_d[0] = d; q_v[0] = v;
      exp_read(0, t_r2, 1'b1, d, v); q_d[1] = d; q_v[1] = v;
      for (int c = 0; c < 2; c++) begin
         if (iss_ok(c)) m_pend[c][t_iaddr] = 1'b1;
         if (wr_ok(c)) begin
            m_regs[c][t_waddr] = t_wdata;
            if (!(iss_ok(c) && t_iaddr == t_waddr)) m_pend[c][t_waddr] = 1'b0;
         end
      end
   endtask

   // One clock: apply inputs, check mid-cycle, advance the model at the edge.
   task automatic cyc(input bit we, input int wa, input int wd, input bit is,
                      input int iad, input int r1, input int r2);
      t_we = we; t_waddr = wa; t_wdata = wd; t_issue = is; t_iaddr = iad; t_r1 = r1; t_r2 = r2;
      drive();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   initial begin
      rst = 1'b1;
      t_we = 0; t_waddr = 0; t_wdata = 0; t_issue = 0; t_iaddr = 0; t_r1 = 0; t_r2 = 0;
      drive();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, i, 7 - i);
      cyc(1, 3, 'hA5, 0, 0, 3, 3);
      cyc(0, 0, 0, 0, 0, 3, 3);
      cyc(1, 0, 'hFF, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 5, 5, 5);
      cyc(0, 0, 0, 0, 0, 5, 2);
      cyc(1, 5, 'h3C, 0, 0, 5, 5);
      cyc(0, 0, 0, 0, 0, 5, 5);
      cyc(1, 6, 'h11, 1, 6, 6, 6);
      cyc(0, 0, 0, 0, 0, 6, 6);
      cyc(1, 6, 'h22, 0, 0, 6, 1);
      cyc(1, 2, 'h77, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 2, 2);
      cyc(0, 0, 0, 0, 0, 2, 6);
      cyc(1, 0, 'h44, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 7);

      for (int n = 0; n < 400; n++) begin
         int wa, r1, r2;
         wa = int'($urandom_range(0, 7));
         r1 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 7));
         r2 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 7));
         cyc(bit'($urandom_range(0, 1)), wa, int'($urandom_range(0, 255)),
             ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)), r1, r2);
      end

      // Asynchronous reset mid-cycle with registers pending.
      cyc(0, 0, 0, 1, 4, 4, 2);
      cyc(0, 0, 0, 1, 3, 4, 3);
      cyc(0, 0, 0, 0, 0, 4, 3);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      t_we = 1; t_waddr = 3; t_wdata = 'h55; t_issue = 1; t_iaddr = 2;
      drive();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0, 3, 2);
      cyc(0, 0, 0, 0, 0, 3, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
